gs_butterfly_mod: RTL and testbench
===================================

// Module: gs_butterfly_mod
// PURPOSE
//  Pipelined Gentleman-Sande (inverse-NTT) butterfly over the Fermat prime 2**M+1.
//  Upstream stage issues one (a, b, twiddle) beat per cycle; this block returns
//    A = (a+b) mod p
//    B = ((a-b)*w) mod p
//  with optional halving of both results for the inverse-transform 1/N scaling.
//  It produces the 2*WIDTH product and folds it internally (lo M bits minus high part).
//  Sits between the inverse-NTT memory read port and the write-back port.
// PARAMETERS
//  WIDTH  18     coefficient/twiddle width; must be >= M+2
//  M      16     Fermat exponent; p = 2**M+1
//  PRIME  65537  modulus, must equal 2**M+1
//  TAG_W  8      width of sideband tag (e.g. write-back address), passed through
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        input beat valid
//  in_ready   out  1        block accepts beat this cycle
//  in_a       in   WIDTH    operand a, 0..p-1
//  in_b       in   WIDTH    operand b, 0..p-1
//  in_w       in   WIDTH    twiddle, 0..p-1
//  in_halve   in   1        1: multiply both results by 2**-1 mod p
//  in_tag     in   TAG_W    sideband, returned unchanged with the result
//  out_valid  out  1        result beat valid
//  out_ready  in   1        downstream accepts result
//  out_a      out  WIDTH    (a+b)[/2] mod p, always 0..p-1
//  out_b      out  WIDTH    ((a-b)[/2]*w) mod p, always 0..p-1
//  out_tag    out  TAG_W    tag of this beat
// BEHAVIOUR
//  Reset: all stage valids, out_valid, out_a, out_b, out_tag = 0.
//   A reset mid-stream discards in-flight beats; in_ready = 1 the cycle after.
//  Pipeline has 3 registered stages (S1, S2, S3); S3 drives out_*.
//   adv = !out_valid | out_ready, and in_ready = adv (combinational).
//   On adv all stages shift one step; when adv = 0 every stage holds.
//   Bubbles are not collapsed.
//   A beat accepted at edge k is presented at edge k+2, i.e. latency 3 cycles, when unstalled.
//  Handshake:
//   Transfer on valid & ready.
//   out_* remain stable while out_valid & !out_ready.
//   Order is preserved; no loss or duplication.
//  S1 (add/sub):
//   s = a+b; if s >= p then s -= p.
//   d = a-b; if negative then d += p.
//   If halve: x even -> x>>1, else (x+p)>>1, applied to s and d; the result stays < p.
//   Register s, d, w, tag.
//  S2: register the full 2*WIDTH product d*w; carry s and tag.
//  S3 (Fermat fold):
//   t = P[M-1:0] - (P >> M), computed signed with WIDTH+1 bits.
//   If t < 0 then t += p; if t >= p then t -= p.
//   Register out_b = t, out_a = s, out_tag = tag.
//   Example: P = 2**32 gives 0 - 65536 + p = 1.
//  Inputs >= p are illegal; the result is then unspecified, but the handshake is still honoured.
// TESTING
//  1 a=5, b=3, w=1, halve=0
//    -> out_a=8, out_b=2, out_valid 3 cycles after acceptance.
//  2 a=0, b=65536, w=65536
//    -> out_a=65536, out_b=65536 (diff wraps to 1).
//  3 a=65536, b=0, w=65536
//    -> out_a=65536, out_b=1 (full 2**32 product folds correctly).
//  4 a=1, b=0, w=1, halve=1
//    -> out_a=32769, out_b=32769; a=4, b=2, w=3, halve=1 -> out_a=3, out_b=3.
//  5 Stream 6 beats, hold out_ready=0 for 4 cycles mid-stream
//    -> in_ready=0 while stalled; out_* stable; all 6 results in order.
//  6 Assert rst for 1 cycle with 3 beats in flight
//    -> out_valid=0 next cycle; none of the 3 beats emerge; a fresh beat then has latency 3.

Source files
------------

// File: rtl/gs_butterfly_mod_if.sv
// Handshake bundle between the inverse-NTT read port, the butterfly and the write-back port.
// master drives beats in and accepts results; slave is the butterfly itself.
interface gs_butterfly_mod_if #(
    parameter int WIDTH = 18,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_w;
    logic             in_halve;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_w, in_halve, in_tag, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_w, in_halve, in_tag, out_ready,
        output in_ready, out_valid, out_a, out_b, out_tag
    );
endinterface

// File: rtl/gs_butterfly_mod.sv
// Three-stage Gentleman-Sande butterfly mod the Fermat prime 2**M+1:
// A = (a+b)[/2], B = ((a-b)[/2]*w), with a global stall driven by the output handshake.
module gs_butterfly_mod #(
    parameter int WIDTH = 18,
    parameter int M     = 16,
    parameter int PRIME = 65537,
    parameter int TAG_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    gs_butterfly_mod_if.slave bus
);

    localparam int XW = WIDTH + 1;
    localparam int PW = 2 * WIDTH;
    localparam logic [XW-1:0] P_X = XW'(PRIME);

    logic             adv;
    logic             v1, v2, v3;
    logic [WIDTH-1:0] s1_s, s1_d, s1_w;
    logic [TAG_W-1:0] s1_tag;
    logic [WIDTH-1:0] s2_s;
    logic [PW-1:0]    s2_p;
    logic [TAG_W-1:0] s2_tag;
    logic [WIDTH-1:0] s3_a, s3_b;
    logic [TAG_W-1:0] s3_tag;

    logic [XW-1:0]    sum_x, diff_x;
    logic [WIDTH-1:0] sum_r, diff_r, sum_h, diff_h;
    logic [XW-1:0]    fold_t, fold_u;
    logic [WIDTH-1:0] fold_r;

    // Odd values are made even by adding p, so the shift stays exact mod p.
    function automatic logic [WIDTH-1:0] halve_mod(input logic [WIDTH-1:0] x);
        logic [XW-1:0] xe;
        xe = {1'b0, x};
        if (x[0]) xe = xe + P_X;
        return WIDTH'(xe >> 1);
    endfunction

    assign adv           = !v3 || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = v3;
    assign bus.out_a     = s3_a;
    assign bus.out_b     = s3_b;
    assign bus.out_tag   = s3_tag;

    always_comb begin
        sum_x  = {1'b0, bus.in_a} + {1'b0, bus.in_b};
        sum_r  = WIDTH'((sum_x >= P_X) ? sum_x - P_X : sum_x);
        diff_x = {1'b0, bus.in_a} + P_X - {1'b0, bus.in_b};
        diff_r = WIDTH'((diff_x >= P_X) ? diff_x - P_X : diff_x);
        sum_h  = bus.in_halve ? halve_mod(sum_r) : sum_r;
        diff_h = bus.in_halve ? halve_mod(diff_r) : diff_r;

        // 2**M == -1 mod p, so the high part of the product is subtracted from the low part.
        fold_t = {{(XW-M){1'b0}}, s2_p[M-1:0]} - XW'(s2_p >> M);
        fold_u = fold_t[XW-1] ? fold_t + P_X : fold_t;
        fold_r = WIDTH'((fold_u >= P_X) ? fold_u - P_X : fold_u);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            s1_s   <= '0;
            s1_d   <= '0;
            s1_w   <= '0;
            s1_tag <= '0;
            s2_s   <= '0;
            s2_p   <= '0;
            s2_tag <= '0;
            s3_a   <= '0;
            s3_b   <= '0;
            s3_tag <= '0;
        end else if (adv) begin
            v1     <= bus.in_valid;
            s1_s   <= sum_h;
            s1_d   <= diff_h;
            s1_w   <= bus.in_w;
            s1_tag <= bus.in_tag;

            v2     <= v1;
            s2_s   <= s1_s;
            s2_p   <= {{WIDTH{1'b0}}, s1_d} * {{WIDTH{1'b0}}, s1_w};
            s2_tag <= s1_tag;

            v3     <= v2;
            s3_a   <= s2_s;
            s3_b   <= fold_r;
            s3_tag <= s2_tag;
        end
    end

endmodule

// File: tb/tb_gs_butterfly_mod.sv
// Bench for gs_butterfly_mod: modular-arithmetic reference model with a scoreboard queue,
// plus directed beats with literal expectations, a mid-stream stall and a mid-stream reset.
module tb_gs_butterfly_mod;
    localparam int     WIDTH = 18;
    localparam int     TAG_W = 8;
    localparam longint P     = 65537;
    localparam longint HINV  = 32769;

    typedef struct {
        longint           ea;
        longint           eb;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gs_butterfly_mod_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus();

    gs_butterfly_mod #(.WIDTH(WIDTH), .M(16), .PRIME(65537), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    logic             stall_prev = 1'b0;
    logic [WIDTH-1:0] held_a, held_b;
    logic [TAG_W-1:0] held_tag;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic void model(input longint a, input longint b, input longint w, input bit h,
                                  output longint ea, output longint eb);
        ea = (a + b) % P;
        eb = (((a - b + P) % P) * w) % P;
        if (h) begin
            ea = (ea * HINV) % P;
            eb = (eb * HINV) % P;
        end
    endfunction

    // Scoreboard: pop on output transfer, push on input transfer, enforce stall stability.
    always @(negedge clk) begin
        exp_t e;
        longint ea, eb;
        if (rst) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_a", bus.out_a, held_a);
                check("stall_b", bus.out_b, held_b);
                check("stall_tag", bus.out_tag, held_tag);
            end
            check("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got a=%0d b=%0d tag=%0d required none",
                             bus.out_a, bus.out_b, bus.out_tag);
                end else begin
                    e = q.pop_front();
                    check("model_a", bus.out_a, e.ea);
                    check("model_b", bus.out_b, e.eb);
                    check("model_tag", bus.out_tag, e.tag);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                model(bus.in_a, bus.in_b, bus.in_w, bus.in_halve, ea, eb);
                e.ea  = ea;
                e.eb  = eb;
                e.tag = bus.in_tag;
                q.push_back(e);
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            held_a     = bus.out_a;
            held_b     = bus.out_b;
            held_tag   = bus.out_tag;
        end
    end

    // Presents one beat just after a rising edge and returns 1ns after the edge that took it.
    task automatic drive_beat(input longint a, input longint b, input longint w, input bit h,
                              input logic [TAG_W-1:0] tag);
        bit acc;
        acc          = 1'b0;
        bus.in_a     = WIDTH'(a);
        bus.in_b     = WIDTH'(b);
        bus.in_w     = WIDTH'(w);
        bus.in_halve = h;
        bus.in_tag   = tag;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (bus.in_ready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for 50 cycles required 1");
        end
    endtask

    task automatic run_one(input string name, input longint a, input longint b, input longint w,
                           input bit h, input logic [TAG_W-1:0] tag,
                           input longint xa, input longint xb);
        int lat;
        bit found;
        lat   = 0;
        found = 1'b0;
        drive_beat(a, b, w, h, tag);
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) found = 1'b1;
        end
        check({name, "_latency"}, lat, 3);
        check({name, "_a"}, bus.out_a, xa);
        check({name, "_b"}, bus.out_b, xb);
        check({name, "_tag"}, bus.out_tag, tag);
        @(posedge clk);
        #1;
    endtask

    longint sa[6] = '{100, 65536, 12345, 0, 65535, 7};
    longint sb[6] = '{200, 65536, 54321, 0, 2, 9};
    longint sw[6] = '{3, 65536, 777, 5, 65536, 2};
    bit     sh[6] = '{0, 0, 1, 1, 0, 1};

    initial begin
        longint ea, eb;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_w      = '0;
        bus.in_halve  = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        model(5, 3, 1, 0, ea, eb);
        check("pin_model_a", ea, 8);
        check("pin_model_b", eb, 2);
        model(65536, 0, 65536, 0, ea, eb);
        check("pin_model_fold", eb, 1);
        model(1, 0, 1, 1, ea, eb);
        check("pin_model_halve", ea, 32769);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_out_a", bus.out_a, 0);
        check("reset_out_b", bus.out_b, 0);
        check("reset_out_tag", bus.out_tag, 0);
        check("reset_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        run_one("basic", 5, 3, 1, 0, 8'h11, 8, 2);
        run_one("diff_wrap", 0, 65536, 65536, 0, 8'h22, 65536, 65536);
        run_one("full_fold", 65536, 0, 65536, 0, 8'h33, 65536, 1);
        run_one("halve_odd", 1, 0, 1, 1, 8'h44, 32769, 32769);
        run_one("halve_even", 4, 2, 3, 1, 8'h55, 3, 3);

        fork
            begin
                for (int i = 0; i < 6; i++) drive_beat(sa[i], sb[i], sw[i], sh[i], TAG_W'(8'h60 + i));
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("stall_in_ready", bus.in_ready, 0);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1;
        check("stream_drained", q.size(), 0);

        for (int i = 0; i < 3; i++) drive_beat(10 + i, 1, 2, 0, TAG_W'(8'h70 + i));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midreset_out_valid", bus.out_valid, 0);
        check("midreset_in_ready", bus.in_ready, 1);
        repeat (5) begin
            @(negedge clk);
            check("midreset_no_emerge", bus.out_valid, 0);
        end
        @(posedge clk);
        #1;
        run_one("after_reset", 9, 4, 2, 0, 8'h7f, 13, 10);

        repeat (5) @(posedge clk);
        #1;
        check("final_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish by 200000ns required finish");
        $fatal(1);
    end

endmodule
